// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer
// Instruction-fetch controller: drives the word address into a combinational
// instruction memory, captures {instr, pc} into a small circular fetch queue
// and hands the queue head to decode over a valid/ready handshake.
// Handles start, redirect with queue flush, back-pressure and the stop at the
// last memory word.
module fetch_sequencer #(
  parameter int N     = 32,   // address / instruction width
  parameter int M     = 256,  // instruction memory depth in words, power of two
  parameter int DEPTH = 2     // fetch queue entries, power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  output logic         busy,
  output logic         done
);

  localparam int AW = $clog2(M);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] LAST_PC    = AW'(M - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_q_instr [DEPTH];
  logic [AW-1:0] r_q_pc    [DEPTH];

  logic          w_head_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_flush;
  logic          w_start;

  // Only the low AW bits of a redirect target address memory; the rest are
  // deliberately dropped.
  logic          w_unused_rpc_hi;
  assign w_unused_rpc_hi = ^redirect_pc[N-1:AW];

  // Queue and fetch control derived from the current state and inputs.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (here unconditionally); a missing assignment on some path infers a latch.
  always_comb begin
    w_head_valid = (r_count != '0);
    w_pop        = w_head_valid && out_ready;
    // A redirect is ignored in IDLE, so it only flushes in RUN or DONE.
    w_flush      = redirect_valid && (r_state != ST_IDLE);
    w_start      = (r_state == ST_IDLE) && start;
    // Fetch while there is room, or when the head leaves on this same edge.
    // A redirect overrides the fetch: nothing is captured on that edge.
    w_push       = (r_state == ST_RUN) && !redirect_valid &&
                   ((r_count < FULL_COUNT) || w_pop);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Capturing the last word ends fetching; a redirect keeps RUN and
        // never coincides with a capture.
        if (w_push && (r_pc == LAST_PC)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (redirect_valid) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: status flags, memory address and queue head.
  always_comb begin
    busy      = (r_state == ST_RUN);
    done      = (r_state == ST_DONE);
    imem_addr = N'(r_pc);
    out_valid = w_head_valid;
    out_instr = '0;
    out_pc    = '0;
    if (w_head_valid) begin
      out_instr = r_q_instr[r_rd_ptr];
      out_pc    = N'(r_q_pc[r_rd_ptr]);
    end
  end

  // Program counter: cleared by start, loaded by redirect, advanced by each
  // capture and held at the last word once it has been captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (w_start) begin
      r_pc <= '0;
    end else if (w_flush) begin
      r_pc <= redirect_pc[AW-1:0];
    end else if (w_push && (r_pc != LAST_PC)) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright even if
  // the head is handed over on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: the fetched word and its pc are written at the tail.
  // NOTE: the storage is reset on purpose so the queue contents are known
  // after reset; with only DEPTH small entries these stay plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_instr;
      r_q_pc[r_wr_ptr]    <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Bench for fetch_sequencer: directed sequences, a stimulus table and a
// randomized run against a transaction-level queue model.
module tb_fetch_sequencer;

  localparam int MEM_WORDS = 256;
  localparam int Q_DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  // Main instance, M = 256.
  logic        start, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, busy, done;

  // Small instance, M = 8, for the end-of-memory sequence.
  logic        start8, redir8, ready8;
  logic [31:0] rpc8;
  logic [31:0] addr8, instr8, oinstr8, opc8;
  logic        valid8, busy8, done8;

  logic [31:0] mem [MEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:0]];
  assign instr8     = mem[{5'd0, addr8[2:0]}];

  fetch_sequencer #(.N(32), .M(256), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy), .done(done)
  );

  fetch_sequencer #(.N(32), .M(8), .DEPTH(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .imem_addr(addr8), .imem_instr(instr8),
    .redirect_valid(redir8), .redirect_pc(rpc8),
    .out_valid(valid8), .out_ready(ready8),
    .out_instr(oinstr8), .out_pc(opc8),
    .busy(busy8), .done(done8)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t m_q[$];
  int   m_mode;   // 0 idle, 1 run, 2 done
  int   m_pc;
  bit   model_on = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_mode = 0;
    m_pc   = 0;
  endtask

  // One clock edge of the fetch rules, applied to a plain queue.
  task automatic model_step();
    bit pop, fetch;
    pop = (m_q.size() != 0) && out_ready;
    case (m_mode)
      0: begin
        if (start) begin
          m_mode = 1;
          m_pc   = 0;
        end
      end
      1: begin
        if (redirect_valid) begin
          m_q.delete();
          m_pc = int'(redirect_pc[7:0]);
        end else begin
          fetch = (m_q.size() < Q_DEPTH) || pop;
          if (pop) void'(m_q.pop_front());
          if (fetch) begin
            m_q.push_back('{pc: 32'(m_pc), instr: mem[m_pc]});
            if (m_pc == MEM_WORDS - 1) m_mode = 2;
            else m_pc++;
          end
        end
      end
      default: begin
        if (pop) void'(m_q.pop_front());
        if (redirect_valid) begin
          m_q.delete();
          m_pc   = int'(redirect_pc[7:0]);
          m_mode = 1;
        end
      end
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    start8 = 1'b0; redir8 = 1'b0; rpc8 = '0; ready8 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic        start;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [31:0] instr_at0, instr_at4, exp_instr;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h002081B3; mem[1] = 32'h00308233; mem[2] = 32'h404182B3;
    mem[3] = 32'h0062F333; mem[4] = 32'h00250163; mem[5] = 32'h001003B3;
    mem[6] = 32'h00138393; mem[7] = 32'hFE000EE3;

    //            start redir rpc         ready | valid pc      addr     busy
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'd0, 32'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'd0, 32'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'd0, 32'd2, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'd0, 32'd2, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'd1, 32'd3, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'd2, 32'd4, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h6,   1'b1, 1'b0, 32'd0, 32'd6, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'd6, 32'd7, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'd7, 32'd8, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h105, 1'b0, 1'b0, 32'd0, 32'd5, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'd5, 32'd6, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'd6, 32'd7, 1'b1};

    // ---- reset state and sequential stream with out_ready held high ----
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_addr", imem_addr, 32'd0);
    check("start_valid", {31'd0, out_valid}, 32'd0);
    instr_at0 = '0; instr_at4 = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("seq_valid", {31'd0, out_valid}, 32'd1);
      check("seq_pc", out_pc, 32'(k));
      check("seq_instr", out_instr, mem[k]);
      check("seq_addr", imem_addr, 32'(k + 1));
      if (k == 0) instr_at0 = out_instr;
      if (k == 4) instr_at4 = out_instr;
    end
    check("instr_pc0", instr_at0, 32'h002081B3);
    check("instr_pc4", instr_at4, 32'h00250163);

    // ---- table: back-pressure, release, redirects incl. 0x105 ----
    do_reset();
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].ready;
      tick();
      exp_instr = vecs[i].exp_valid ? mem[vecs[i].exp_pc[7:0]] : 32'd0;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), out_instr, exp_instr);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end
    start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;

    // ---- end of memory with M = 8 ----
    do_reset();
    start8 = 1'b1; ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("m8_start_addr", addr8, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("m8_pc", opc8, 32'(k));
      check("m8_instr", oinstr8, mem[k]);
      check("m8_addr", addr8, (k < 7) ? 32'(k + 1) : 32'd7);
      check("m8_done", {31'd0, done8}, (k < 7) ? 32'd0 : 32'd1);
      check("m8_busy", {31'd0, busy8}, (k < 7) ? 32'd1 : 32'd0);
    end
    start8 = 1'b1;   // start is ignored in DONE
    tick();
    start8 = 1'b0;
    check("m8_drain_valid", {31'd0, valid8}, 32'd0);
    check("m8_drain_addr", addr8, 32'd7);
    check("m8_drain_done", {31'd0, done8}, 32'd1);
    tick();
    check("m8_hold_addr", addr8, 32'd7);
    check("m8_hold_valid", {31'd0, valid8}, 32'd0);
    redir8 = 1'b1; rpc8 = 32'd0;
    tick();
    redir8 = 1'b0;
    check("m8_redir_busy", {31'd0, busy8}, 32'd1);
    check("m8_redir_done", {31'd0, done8}, 32'd0);
    check("m8_redir_addr", addr8, 32'd0);
    check("m8_redir_valid", {31'd0, valid8}, 32'd0);
    tick();
    check("m8_resume_pc", opc8, 32'd0);
    check("m8_resume_valid", {31'd0, valid8}, 32'd1);
    ready8 = 1'b0;

    // ---- asynchronous reset with the queue full ----
    do_reset();
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("full_pc", out_pc, 32'd0);
    check("full_addr", imem_addr, 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("arst_refetch0", out_pc, 32'd0);
    check("arst_refetch0_v", {31'd0, out_valid}, 32'd1);
    tick();
    check("arst_refetch1", out_pc, 32'd1);

    // ---- randomized run against the queue model ----
    do_reset();
    model_reset();
    model_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start          = ($urandom_range(7) == 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(3) != 0);
      tick();
      check("rnd_valid", {31'd0, out_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
      check("rnd_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'd0);
      check("rnd_instr", out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'd0);
      check("rnd_addr", imem_addr, 32'(m_pc));
      check("rnd_busy", {31'd0, busy}, (m_mode == 1) ? 32'd1 : 32'd0);
      check("rnd_done", {31'd0, done}, (m_mode == 2) ? 32'd1 : 32'd0);
    end
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
